// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: exception flag bit positions, cause codes
// and the trap controller state encoding.
package machine_mode_types_1_12_pkg;

  localparam int unsigned N_TRAP_FLAGS = 11;

  // Bit positions within exc_flags; the hazard side already folds the
  // data-side protection faults into fault_l / fault_s.
  typedef enum logic [3:0] {
    FLAG_FAULT_INSN   = 4'd0,
    FLAG_PROT_FAULT_I = 4'd1,
    FLAG_ILLEGAL_INSN = 4'd2,
    FLAG_MAL_INSN     = 4'd3,
    FLAG_BREAKPOINT   = 4'd4,
    FLAG_ENV_M        = 4'd5,
    FLAG_MAL_L        = 4'd6,
    FLAG_MAL_S        = 4'd7,
    FLAG_FAULT_L      = 4'd8,
    FLAG_FAULT_S      = 4'd9,
    FLAG_EX_RMGMT     = 4'd10
  } trap_flag_e;

  typedef enum logic [4:0] {
    EXC_MAL_INSN     = 5'd0,
    EXC_FAULT_INSN   = 5'd1,
    EXC_ILLEGAL_INSN = 5'd2,
    EXC_BREAKPOINT   = 5'd3,
    EXC_MAL_L        = 5'd4,
    EXC_FAULT_L      = 5'd5,
    EXC_MAL_S        = 5'd6,
    EXC_FAULT_S      = 5'd7,
    EXC_ENV_M        = 5'd11,
    EXC_RMGMT        = 5'd24
  } exc_cause_e;

  typedef enum logic [4:0] {
    INT_SOFT_M  = 5'd3,
    INT_TIMER_M = 5'd7,
    INT_EXT_M   = 5'd11
  } int_cause_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_e;

  // Exception causes that report the faulting address in mtval.
  function automatic logic cause_has_tval(input logic [4:0] c);
    return (c == EXC_MAL_INSN) || (c == EXC_FAULT_INSN) ||
           (c == EXC_MAL_L)    || (c == EXC_FAULT_L)    ||
           (c == EXC_MAL_S)    || (c == EXC_FAULT_S);
  endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: exceptions first, then enabled interrupts.
module prv_trap_prio
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [10:0] exc_flags,
  input  logic [2:0]  int_pend,
  input  logic [2:0]  int_en,
  input  logic        mstatus_mie,
  output logic        valid,
  output logic        is_int,
  output logic [4:0]  cause
);

  logic [2:0] int_act;

  assign int_act = int_pend & int_en & {3{mstatus_mie}};

  always_comb begin
    valid  = 1'b1;
    is_int = 1'b0;
    cause  = '0;
    if (exc_flags[FLAG_FAULT_INSN] || exc_flags[FLAG_PROT_FAULT_I]) cause = EXC_FAULT_INSN;
    else if (exc_flags[FLAG_ILLEGAL_INSN])                       cause = EXC_ILLEGAL_INSN;
    else if (exc_flags[FLAG_MAL_INSN])                           cause = EXC_MAL_INSN;
    else if (exc_flags[FLAG_BREAKPOINT])                         cause = EXC_BREAKPOINT;
    else if (exc_flags[FLAG_ENV_M])                              cause = EXC_ENV_M;
    else if (exc_flags[FLAG_MAL_L])                              cause = EXC_MAL_L;
    else if (exc_flags[FLAG_MAL_S])                              cause = EXC_MAL_S;
    else if (exc_flags[FLAG_FAULT_L])                            cause = EXC_FAULT_L;
    else if (exc_flags[FLAG_FAULT_S])                            cause = EXC_FAULT_S;
    else if (exc_flags[FLAG_EX_RMGMT])                           cause = EXC_RMGMT;
    else begin
      is_int = 1'b1;
      // int_pend/int_en order is {ext, soft, timer}
      if (int_act[2])      cause = INT_EXT_M;
      else if (int_act[1]) cause = INT_SOFT_M;
      else if (int_act[0]) cause = INT_TIMER_M;
      else begin
        valid  = 1'b0;
        is_int = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap/MRET sequencer: latch on detect, drain, commit CSRs, redirect.
module prv_trap_ctrl
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic [10:0] exc_flags,
  input  logic        ret,
  input  logic [2:0]  int_pend,
  input  logic [2:0]  int_en,
  input  logic        mstatus_mie,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        pipe_clear,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mtval_wdata,
  output logic        trap_we,
  output logic        mret_we
);

  trap_state_e state_q, state_d;

  logic        p_valid, p_is_int;
  logic [4:0]  p_cause;
  logic [31:0] base, trap_target;
  logic [31:0] cause_q, epc_q, tval_q, target_q;
  logic        is_ret_q;

  prv_trap_prio u_prio (
    .exc_flags   (exc_flags),
    .int_pend    (int_pend),
    .int_en      (int_en),
    .mstatus_mie (mstatus_mie),
    .valid       (p_valid),
    .is_int      (p_is_int),
    .cause       (p_cause)
  );

  assign base        = {mtvec[31:2], 2'b00};
  assign trap_target = (p_is_int && (mtvec[1:0] == 2'b01))
                     ? base + {25'd0, p_cause, 2'b00} : base;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (p_valid || ret) state_d = DRAIN;
      DRAIN:    if (pipe_clear)     state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Captured only on the IDLE exit so inputs are ignored for the whole sequence.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      is_ret_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (p_valid) begin
        cause_q  <= {p_is_int, 26'd0, p_cause};
        epc_q    <= epc;
        tval_q   <= (!p_is_int && cause_has_tval(p_cause)) ? badaddr : '0;
        target_q <= trap_target;
        is_ret_q <= 1'b0;
      end else if (ret) begin
        target_q <= mepc;
        is_ret_q <= 1'b1;
      end
    end
  end

  always_comb begin
    intr      = (state_q != IDLE);
    trap_we   = (state_q == COMMIT) && !is_ret_q;
    mret_we   = (state_q == COMMIT) &&  is_ret_q;
    insert_pc = (state_q == REDIRECT);
  end

  assign priv_pc      = target_q;
  assign mcause_wdata = cause_q;
  assign mepc_wdata   = epc_q;
  assign mtval_wdata  = tval_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed bench for prv_trap_ctrl with immediate-assertion checks.
module tb_prv_trap_ctrl;
  import machine_mode_types_1_12_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [10:0] exc_flags;
  logic        ret;
  logic [2:0]  int_pend, int_en;
  logic        mstatus_mie;
  logic [31:0] epc, badaddr, mtvec, mepc;
  logic        pipe_clear;
  logic        intr, insert_pc, trap_we, mret_we;
  logic [31:0] priv_pc, mcause_wdata, mepc_wdata, mtval_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  prv_trap_ctrl dut (
    .CLK(CLK), .nRST(nRST), .exc_flags(exc_flags), .ret(ret),
    .int_pend(int_pend), .int_en(int_en), .mstatus_mie(mstatus_mie),
    .epc(epc), .badaddr(badaddr), .pipe_clear(pipe_clear), .mtvec(mtvec),
    .mepc(mepc), .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc),
    .mcause_wdata(mcause_wdata), .mepc_wdata(mepc_wdata),
    .mtval_wdata(mtval_wdata), .trap_we(trap_we), .mret_we(mret_we)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    exc_flags = '0; ret = 1'b0; int_pend = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {28'd0, intr, insert_pc, trap_we, mret_we}, 32'd0);
    chk({tag, ".priv_pc"}, priv_pc, 32'd0);
    chk({tag, ".mcause"}, mcause_wdata, 32'd0);
    chk({tag, ".mepc"}, mepc_wdata, 32'd0);
    chk({tag, ".mtval"}, mtval_wdata, 32'd0);
  endtask

  initial begin
    nRST = 1'b0; idle_inputs();
    int_en = '0; mstatus_mie = 1'b0; epc = '0; badaddr = '0;
    mtvec = '0; mepc = '0; pipe_clear = 1'b1;
    #12;
    chk_all_zero("reset");
    nRST = 1'b1;
    tick();

    // 1: illegal instruction, direct mode
    exc_flags[FLAG_ILLEGAL_INSN] = 1'b1; epc = 32'h100; mtvec = 32'h200;
    badaddr = 32'hAAAA_0000;
    tick(); idle_inputs(); epc = 32'hFFFF_0000;
    chk("ill.drain_intr", {31'd0, intr}, 32'd1);
    chk("ill.drain_we", {31'd0, trap_we}, 32'd0);
    tick();
    chk("ill.trap_we", {31'd0, trap_we}, 32'd1);
    chk("ill.mret_we", {31'd0, mret_we}, 32'd0);
    chk("ill.mcause", mcause_wdata, 32'd2);
    chk("ill.mepc", mepc_wdata, 32'h100);
    chk("ill.mtval", mtval_wdata, 32'd0);
    tick();
    chk("ill.insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("ill.priv_pc", priv_pc, 32'h200);
    chk("ill.redir_we", {31'd0, trap_we}, 32'd0);
    tick();
    chk("ill.back_idle", {30'd0, intr, insert_pc}, 32'd0);

    // 2: fault_insn beats mal_l and an external interrupt
    exc_flags[FLAG_FAULT_INSN] = 1'b1; exc_flags[FLAG_MAL_L] = 1'b1;
    int_pend = 3'b100; int_en = 3'b111; mstatus_mie = 1'b1;
    epc = 32'h300; badaddr = 32'hDEAD_BEE0; mtvec = 32'h201;
    tick(); idle_inputs();
    tick();
    chk("fi.mcause", mcause_wdata, 32'd1);
    chk("fi.mtval", mtval_wdata, 32'hDEAD_BEE0);
    chk("fi.mepc", mepc_wdata, 32'h300);
    tick();
    chk("fi.priv_pc", priv_pc, 32'h200);
    tick();

    // 3: soft beats timer, vectored; pending drops during drain
    int_pend = 3'b011; int_en = 3'b011; mstatus_mie = 1'b1; mtvec = 32'h1001;
    epc = 32'h500; pipe_clear = 1'b0;
    tick(); int_pend = '0; pipe_clear = 1'b1;
    tick();
    chk("soft.trap_we", {31'd0, trap_we}, 32'd1);
    chk("soft.mcause", mcause_wdata, 32'h8000_0003);
    chk("soft.mtval", mtval_wdata, 32'd0);
    tick();
    chk("soft.insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("soft.priv_pc", priv_pc, 32'h100C);
    tick();

    // 4: exception in vectored mode goes to base; concurrent ret ignored
    exc_flags[FLAG_EX_RMGMT] = 1'b1; ret = 1'b1; mepc = 32'h777;
    tick(); idle_inputs();
    tick();
    chk("rm.trap_we", {31'd0, trap_we}, 32'd1);
    chk("rm.mret_we", {31'd0, mret_we}, 32'd0);
    chk("rm.mcause", mcause_wdata, 32'd24);
    tick();
    chk("rm.priv_pc", priv_pc, 32'h1000);
    tick();

    // 5: MRET with a slow drain
    ret = 1'b1; mepc = 32'h400; pipe_clear = 1'b0; mtvec = 32'h200;
    tick(); ret = 1'b0; mepc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("ret.drain_intr", {31'd0, intr}, 32'd1);
      chk("ret.drain_ctl", {29'd0, insert_pc, trap_we, mret_we}, 32'd0);
      tick();
    end
    pipe_clear = 1'b1;
    tick();
    chk("ret.mret_we", {31'd0, mret_we}, 32'd1);
    chk("ret.trap_we", {31'd0, trap_we}, 32'd0);
    chk("ret.intr", {31'd0, intr}, 32'd1);
    tick();
    chk("ret.insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("ret.priv_pc", priv_pc, 32'h400);
    tick();

    // 6: masked interrupts never trap
    int_pend = 3'b111; int_en = 3'b111; mstatus_mie = 1'b0;
    tick(); tick();
    chk("mask.mie0", {31'd0, intr}, 32'd0);
    mstatus_mie = 1'b1; int_en = 3'b000;
    tick(); tick();
    chk("mask.en0", {31'd0, intr}, 32'd0);
    idle_inputs();

    // 7: reset during drain abandons the trap
    exc_flags[FLAG_MAL_S] = 1'b1; badaddr = 32'h1234; pipe_clear = 1'b0;
    tick(); idle_inputs();
    chk("rst.pre_intr", {31'd0, intr}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk_all_zero("rst.async");
    pipe_clear = 1'b1;
    #3 nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst.quiet", {28'd0, intr, insert_pc, trap_we, mret_we}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench did not terminate");
  end

endmodule

// File: doc/prv_trap_ctrl.md
PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset. Ports are listed as name, direction, width, meaning, with CLK and nRST first:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- exc_flags  in  11  raw exception flags from the hazard side; bit order per trap_flag_e
- ret  in  1  MRET in commit
- int_pend  in  3  {ext, soft, timer} pending
- int_en  in  3  {meie, msie, mtie}
- mstatus_mie  in  1  global interrupt enable
- epc  in  32  PC of the faulting/committing instruction
- badaddr  in  32  faulting address
- pipe_clear  in  1  pipeline drained
- mtvec  in  32  trap vector CSR
- mepc  in  32  current mepc CSR
- intr  out  1  flush request to hazard unit
- insert_pc  out  1  redirect strobe
- priv_pc  out  32  redirect target
- mcause_wdata  out  32  cause value
- mepc_wdata  out  32  saved PC
- mtval_wdata  out  32  trap value
- trap_we  out  1  write mcause/mepc/mtval and push mstatus (MPIE<=MIE, MIE<=0)
- mret_we  out  1  pop mstatus (MIE<=MPIE)

Function
REQ-002 SHALL implement states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-003 In IDLE, a trap SHALL be any exc_flags bit set, or (mstatus_mie & |(int_pend & int_en)).
- Trap present: latch cause, epc and tval, then go to DRAIN.
- Otherwise ret=1: latch mepc as the target, set the ret marker, then go to DRAIN.
REQ-004 intr SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-005 DRAIN SHALL hold until pipe_clear=1, then go to COMMIT. There is no timeout.
REQ-006 COMMIT SHALL last exactly one cycle.
- Trap: trap_we=1.
- Ret: mret_we=1.
- Next state: REDIRECT.
REQ-007 REDIRECT SHALL last one cycle with insert_pc=1 and priv_pc equal to the latched target, then return to IDLE.
REQ-008 Minimum latency from trap detect to insert_pc SHALL be 3 cycles (pipe_clear already 1).
REQ-009 Exception priority, highest first, SHALL be as follows (cause code in parentheses):
- fault_insn or prot_fault_i (1)
- illegal_insn (2)
- mal_insn (0)
- breakpoint (3)
- env_m (11)
- mal_l (4)
- mal_s (6)
- fault_l or prot_fault_l (5)
- fault_s or prot_fault_s (7)
- ex_rmgmt (24)
REQ-010 Any exception SHALL outrank any interrupt; ret SHALL be ignored when a trap is present in the same cycle.
REQ-011 Interrupt priority SHALL be ext (11) > soft (3) > timer (7); mcause_wdata[31]=1 for interrupts and 0 for exceptions.
REQ-012 mtval_wdata SHALL equal badaddr for fault/misaligned causes and 0 otherwise; mepc_wdata SHALL equal the latched epc.
REQ-013 The target SHALL be {mtvec[31:2],2'b00}, except when mtvec[1:0]=01 and the trap is an interrupt, where it SHALL be base + 4*cause using 32-bit wrap-around addition.
REQ-014 Inputs SHALL be ignored outside IDLE; the latched cause, epc and target SHALL remain stable until IDLE.
REQ-015 When pipe_clear=1 and int_pend=0 during DRAIN for an interrupt trap, the trap SHALL still complete.

Reset
REQ-016 On nRST=0 the block SHALL enter IDLE at once, drive every output to 0, and clear all latches; a trap in progress SHALL be abandoned with no CSR strobe.

Structure
REQ-017 trap_flag_e (the exc_flags bit indices), the exception/interrupt cause enums and trap_state_e SHALL live in machine_mode_types_1_12_pkg.
REQ-018 The priority encoder SHALL be a combinational sub-module, prv_trap_prio, which outputs valid, is_int and cause[4:0].

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- illegal_insn=1 with epc=0x100, mtvec=0x200 and pipe_clear=1 -> trap_we at cycle+2 with mcause=2, mepc=0x100, mtval=0; insert_pc at cycle+3 with priv_pc=0x200.
- fault_insn, mal_l and ext interrupt together -> mcause=1, mtval=badaddr.
- timer+soft pending, both enabled, mstatus_mie=1, mtvec=0x1001 -> mcause=0x80000003, priv_pc=0x100C.
- ret=1 with mepc=0x400 and pipe_clear held at 0 for 5 cycles -> intr high for 5 cycles, then mret_we, then insert_pc with priv_pc=0x400; trap_we stays 0.
- Interrupt pending with mstatus_mie=0 -> no intr; with mie=1 but int_en=0 -> no intr.
- nRST asserted during DRAIN -> all outputs 0 immediately; after release, no trap_we/insert_pc without new stimulus.
